// File: rtl/acc_adder_pkg.sv
// Shared types and defaults for the acc_adder pipelined adder/accumulator.
package acc_adder_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        ACC  = 2'b01,
        SAT  = 2'b10,
        RSVD = 2'b11
    } mode_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_ACC_W = 8;

    function automatic logic is_acc(input mode_t m);
        return m == ACC;
    endfunction

endpackage

// File: rtl/acc_adder_pipe_slice.sv
// Single-entry valid/ready register slice with a parametrised payload.
module pipe_slice #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Accept whenever empty or the downstream drains this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/acc_adder.sv
// Two-stage elastic adder: S1 is a register slice for operands, S2 computes
// ADD/SAT/ACC results and owns the running accumulator.
module acc_adder
    import acc_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    if (WIDTH < 1) begin : g_bad_width
        $error("acc_adder: WIDTH must be at least 1");
    end
    if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
        $error("acc_adder: ACC_W must be at least WIDTH+1");
    end

    localparam int unsigned PW = 2 * WIDTH + 3;

    logic [PW-1:0]    s1_in_data;
    logic [PW-1:0]    s1_data;
    logic             s1_valid;
    logic             s2_adv;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    mode_t            s1_mode;
    logic             s1_clr;

    logic             s2_valid_q;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic [ACC_W-1:0] acc_q;

    logic [WIDTH:0]   raw_sum;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_tot;
    logic [ACC_W-1:0] sum_c;
    logic             ovf_c;

    assign s1_in_data = {a, b, mode, acc_clr};

    pipe_slice #(
        .DW (PW)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_adv),
        .out_data  (s1_data)
    );

    assign s1_clr  = s1_data[0];
    assign s1_mode = mode_t'(s1_data[2:1]);
    assign s1_b    = s1_data[WIDTH+2:3];
    assign s1_a    = s1_data[2*WIDTH+2:WIDTH+3];

    assign s2_adv = !s2_valid_q || out_ready;

    always_comb begin
        raw_sum  = {1'b0, s1_a} + {1'b0, s1_b};
        acc_base = s1_clr ? '0 : acc_q;
        // a+b fits in ACC_W bits, so the three-term sum carries at most once.
        acc_tot  = {1'b0, acc_base} + (ACC_W + 1)'(s1_a) + (ACC_W + 1)'(s1_b);
        sum_c    = ACC_W'(raw_sum);
        ovf_c    = raw_sum[WIDTH];
        case (s1_mode)
            ACC: begin
                sum_c = acc_tot[ACC_W-1:0];
                ovf_c = acc_tot[ACC_W];
            end
            SAT: begin
                if (raw_sum[WIDTH]) begin
                    sum_c = ACC_W'({WIDTH{1'b1}});
                    ovf_c = 1'b1;
                end
            end
            default: begin
                sum_c = ACC_W'(raw_sum);
                ovf_c = raw_sum[WIDTH];
            end
        endcase
    end

    // Accumulator moves only with a beat leaving S1, so stalls cannot double-apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q <= sum_c;
                ovf_q <= ovf_c;
                if (is_acc(s1_mode)) begin
                    acc_q <= acc_tot[ACC_W-1:0];
                end else if (s1_clr) begin
                    acc_q <= '0;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/acc_adder.md
ACC_ADDER -- requirements
Module: acc_adder

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, at least 1.
REQ-002 Parameter ACC_W, default 8: result and accumulator width; elaboration SHALL fail if ACC_W < WIDTH+1.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 mode  input  2  00 ADD, 01 ACC, 10 SAT, 11 reserved (SHALL behave as ADD).
REQ-010 acc_clr  input  1  sideband qualified with the beat: zero the accumulator before this beat.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  ACC_W  result, unsigned.
REQ-014 ovf  output  1  overflow or saturation flag for this result.

Function
REQ-015 The block SHALL be a 2-stage elastic pipeline: S1 registers a, b, mode and acc_clr; S2 computes and registers sum and ovf.
REQ-016 A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-017 S2 SHALL advance when !S2.valid || out_ready; S1 SHALL advance when S2 advances or S1 is empty; in_ready = !S1.valid || S2-advance.
REQ-018 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, and throughput SHALL be 1 beat per cycle with no bubbles.
REQ-019 While out_valid && !out_ready, sum and ovf SHALL hold stable, and out_valid SHALL NOT drop.
REQ-020 ADD: sum = zero-extended a+b; ovf = bit WIDTH of a+b.
REQ-021 SAT: sum = min(a+b, 2^WIDTH-1), zero-extended; ovf = 1 when clipping occurred.
REQ-022 ACC: acc_next = (acc_clr ? 0 : acc) + a + b, modulo 2^ACC_W; sum = acc_next; ovf = carry out of bit ACC_W-1.
REQ-023 The accumulator SHALL update only when an ACC beat moves from S1 into S2; ADD and SAT beats SHALL leave it unchanged.
REQ-024 acc_clr on a non-ACC beat SHALL zero the accumulator and SHALL NOT affect that beat's result.
REQ-025 A stall SHALL NOT cause double accumulation: each accepted beat is applied exactly once.

Reset
REQ-026 While rst is high: S1.valid = S2.valid = 0, accumulator = 0, sum = 0, ovf = 0, out_valid = 0; in_ready SHALL read 1.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats without emitting them; the first beat after reset SHALL accumulate from 0.

Structure
REQ-028 Package acc_adder_pkg SHALL hold the mode_t enum (ADD, ACC, SAT, RSVD) and the default WIDTH/ACC_W constants.
REQ-029 Sub-module pipe_slice (parametrised payload width, valid/ready register slice) SHALL be instantiated for S1; S2 holds the arithmetic and accumulator locally.

Verification
REQ-030 WIDTH=4, ACC_W=8, ADD a=15, b=15, out_ready=1 -> sum=30 and ovf=1 exactly 2 cycles after transfer.
REQ-031 SAT a=9, b=8 -> sum=15, ovf=1; SAT a=3, b=4 -> sum=7, ovf=0.
REQ-032 ACC beats (1,2), (3,4), then (5,5) with acc_clr=1 -> sums 3, 10, 10.
REQ-033 ACC run totalling 250 followed by beat (4,4) -> sum=2, ovf=1 (wrap).
REQ-034 10 back-to-back ACC beats of (1,0) with out_ready toggled randomly -> outputs 1..10 in order, each exactly once, and stalled outputs stable.
REQ-035 rst pulsed with 2 beats in flight -> neither beat emitted; next ACC beat (2,3) -> sum=5.
